// File: rtl/learn_guide_pkg.sv
// Shared types and constants for the learn-mode lesson sequencer.
// Note encoding: 0 = no key, 1..7 = key, anything above 7 reads as no key.
package learn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHOW,
        RELEASE
    } state_t;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_MAX  = 4'd7;
    localparam int         KEY_W     = 7;

    function automatic logic [3:0] clean_note(input logic [3:0] n);
        return (n > NOTE_MAX) ? NOTE_NONE : n;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/learn_guide_if.sv
// Bundle of song ROM, key decoder and LED-bank signals around learn_guide.
// The slave modport is the sequencer side; master is its environment.
interface learn_guide_if #(
    parameter int ADDR_W = 6
) ();
    import learn_pkg::*;

    logic              start;
    logic [3:0]        note_in;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_note;
    logic [KEY_W-1:0]  led_out;
    logic              busy;
    logic              done;
    logic              wrong;
    logic [7:0]        score;
    logic [7:0]        miss_cnt;

    modport master (
        output start, note_in, rom_note,
        input  rom_addr, led_out, busy, done, wrong, score, miss_cnt
    );

    modport slave (
        input  start, note_in, rom_note,
        output rom_addr, led_out, busy, done, wrong, score, miss_cnt
    );

endinterface

// File: rtl/learn_guide_note_to_led.sv
// Note number to one-hot key LED (bit 6 = note 1 ... bit 0 = note 7).
// Out-of-range notes give an all-dark bank; the key decoder is the inverse.
module note_to_led
    import learn_pkg::*;
(
    input  logic [3:0]       note_i,
    output logic [KEY_W-1:0] led_o
);

    always_comb begin
        led_o = '0;
        case (note_i)
            4'd1:    led_o = 7'b1000000;
            4'd2:    led_o = 7'b0100000;
            4'd3:    led_o = 7'b0010000;
            4'd4:    led_o = 7'b0001000;
            4'd5:    led_o = 7'b0000100;
            4'd6:    led_o = 7'b0000010;
            4'd7:    led_o = 7'b0000001;
            default: led_o = '0;
        endcase
    end

endmodule

// File: rtl/learn_guide.sv
// Learn-mode lesson sequencer: walks the song ROM, lights the next key,
// scores hits and counts wrong presses and per-note timeouts.
module learn_guide
    import learn_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input logic          clk,
    input logic          rst,
    learn_guide_if.slave bus
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        expect_q, expect_d;
    logic [3:0]        prev_q;
    logic [3:0]        note_now;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [KEY_W-1:0]  led_q, led_d, led_load;
    logic              busy_q;
    logic              done_q, done_d;
    logic              wrong_q, wrong_d;
    logic [7:0]        score_q, score_d;
    logic [7:0]        miss_q, miss_d;
    logic              rom_valid;

    note_to_led u_note_to_led (
        .note_i (bus.rom_note),
        .led_o  (led_load)
    );

    always_comb begin
        note_now  = clean_note(bus.note_in);
        rom_valid = (bus.rom_note != NOTE_NONE) && (bus.rom_note <= NOTE_MAX);

        state_d  = state_q;
        addr_d   = addr_q;
        expect_d = expect_q;
        tmr_d    = tmr_q;
        led_d    = led_q;
        done_d   = 1'b0;
        wrong_d  = 1'b0;
        score_d  = score_q;
        miss_d   = miss_q;

        case (state_q)
            IDLE: begin
                led_d = '0;
                if (bus.start) begin
                    score_d = '0;
                    miss_d  = '0;
                    addr_d  = '0;
                    tmr_d   = '0;
                    state_d = FETCH;
                end
            end

            FETCH: state_d = LOAD;

            LOAD: begin
                if (rom_valid) begin
                    expect_d = bus.rom_note;
                    led_d    = led_load;
                    tmr_d    = '0;
                    state_d  = SHOW;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            SHOW: begin
                tmr_d = tmr_q + 1'b1;
                // Hit outranks timeout, which outranks a wrong press.
                if (note_now == expect_q) begin
                    score_d = sat_inc(score_q);
                    led_d   = '0;
                    state_d = RELEASE;
                end else if (tmr_q == TMR_LAST) begin
                    miss_d  = sat_inc(miss_q);
                    led_d   = '0;
                    state_d = RELEASE;
                end else if (note_now != NOTE_NONE && prev_q == NOTE_NONE) begin
                    wrong_d = 1'b1;
                    miss_d  = sat_inc(miss_q);
                end
            end

            RELEASE: begin
                // Waiting for all keys up keeps a held key from hitting a repeated note.
                if (note_now == NOTE_NONE) begin
                    if (&addr_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            expect_q <= '0;
            prev_q   <= '0;
            tmr_q    <= '0;
            led_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrong_q  <= 1'b0;
            score_q  <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            expect_q <= expect_d;
            prev_q   <= note_now;
            tmr_q    <= tmr_d;
            led_q    <= led_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
            wrong_q  <= wrong_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.led_out  = led_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wrong    = wrong_q;
    assign bus.score    = score_q;
    assign bus.miss_cnt = miss_q;

endmodule

// File: tb/tb_learn_guide.sv
// Directed bench for learn_guide: two instances (64-entry song with a short
// timeout, 4-entry song with a long timeout) driven from hand-timed vectors.
module tb_learn_guide;
    import learn_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    learn_guide_if #(.ADDR_W(6)) ifa ();
    learn_guide_if #(.ADDR_W(2)) ifb ();

    learn_guide #(.ADDR_W(6), .TIMEOUT_CYCLES(10)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    learn_guide #(.ADDR_W(2), .TIMEOUT_CYCLES(1000)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    logic [3:0] rom_a [64];
    logic [3:0] rom_b [4];

    always @(posedge clk) begin
        ifa.rom_note <= rom_a[ifa.rom_addr];
        ifb.rom_note <= rom_b[ifb.rom_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_rom_a(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2);
        for (int i = 0; i < 64; i++) rom_a[i] = 4'd0;
        rom_a[0] = n0;
        rom_a[1] = n1;
        rom_a[2] = n2;
    endtask

    // Leaves the bench at the first FETCH cycle; the LED is valid two cycles later.
    task automatic start_a();
        ifa.start = 1'b1;
        cyc(1);
        ifa.start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            cyc(1);
            if (ifa.done) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        ifa.start    = 1'b0;
        ifa.note_in  = 4'd0;
        ifb.start    = 1'b0;
        ifb.note_in  = 4'd0;
        load_rom_a(4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) rom_b[i] = 4'd1;
        cyc(2);

        check_eq("rst_addr",  32'(ifa.rom_addr), 32'd0);
        check_eq("rst_led",   32'(ifa.led_out),  32'd0);
        check_eq("rst_busy",  32'(ifa.busy),     32'd0);
        check_eq("rst_done",  32'(ifa.done),     32'd0);
        check_eq("rst_wrong", 32'(ifa.wrong),    32'd0);
        check_eq("rst_score", 32'(ifa.score),    32'd0);
        check_eq("rst_miss",  32'(ifa.miss_cnt), 32'd0);
        rst = 1'b0;
        cyc(1);

        // Two-note song {3,5}
        load_rom_a(4'd3, 4'd5, 4'd0);
        start_a();
        check_eq("t1_busy", 32'(ifa.busy), 32'd1);
        cyc(2);
        check_eq("t1_led3", 32'(ifa.led_out), 32'b0010000);
        ifa.note_in = 4'd3;
        cyc(1);
        check_eq("t1_score1", 32'(ifa.score), 32'd1);
        check_eq("t1_led_off", 32'(ifa.led_out), 32'd0);
        ifa.note_in = 4'd0;
        cyc(2);
        check_eq("t1_led_gap", 32'(ifa.led_out), 32'd0);
        cyc(1);
        check_eq("t1_led5", 32'(ifa.led_out), 32'b0000100);
        ifa.note_in = 4'd5;
        cyc(1);
        check_eq("t1_score2", 32'(ifa.score), 32'd2);
        ifa.note_in = 4'd0;
        cyc(2);
        check_eq("t1_done_early", 32'(ifa.done), 32'd0);
        check_eq("t1_busy_late",  32'(ifa.busy), 32'd1);
        cyc(1);
        check_eq("t1_done",     32'(ifa.done), 32'd1);
        check_eq("t1_busy_off", 32'(ifa.busy), 32'd0);
        cyc(1);
        check_eq("t1_done_1cyc", 32'(ifa.done),     32'd0);
        check_eq("t1_score_hold", 32'(ifa.score),   32'd2);
        check_eq("t1_miss",      32'(ifa.miss_cnt), 32'd0);

        // Wrong press before the right one
        load_rom_a(4'd4, 4'd0, 4'd0);
        start_a();
        cyc(2);
        check_eq("t2_led4", 32'(ifa.led_out), 32'b0001000);
        ifa.note_in = 4'd1;
        cyc(1);
        check_eq("t2_wrong", 32'(ifa.wrong),    32'd1);
        check_eq("t2_miss",  32'(ifa.miss_cnt), 32'd1);
        cyc(1);
        check_eq("t2_wrong_held", 32'(ifa.wrong),    32'd0);
        check_eq("t2_miss_held",  32'(ifa.miss_cnt), 32'd1);
        ifa.note_in = 4'd0;
        cyc(1);
        ifa.note_in = 4'd4;
        cyc(1);
        check_eq("t2_score", 32'(ifa.score),    32'd1);
        check_eq("t2_miss2", 32'(ifa.miss_cnt), 32'd1);
        ifa.note_in = 4'd0;
        wait_done_a("t2_done", 10);

        // Timeout on note 2, then note 7 with an out-of-range key value
        load_rom_a(4'd2, 4'd7, 4'd0);
        start_a();
        cyc(2);
        check_eq("t3_led2", 32'(ifa.led_out), 32'b0100000);
        cyc(9);
        check_eq("t3_lit_last", 32'(ifa.led_out), 32'b0100000);
        cyc(1);
        check_eq("t3_led_timeout", 32'(ifa.led_out),  32'd0);
        check_eq("t3_miss",        32'(ifa.miss_cnt), 32'd1);
        cyc(3);
        check_eq("t3_led7", 32'(ifa.led_out), 32'b0000001);
        ifa.note_in = 4'd9;
        cyc(1);
        check_eq("t3_hi_no_wrong", 32'(ifa.wrong),    32'd0);
        check_eq("t3_hi_no_miss",  32'(ifa.miss_cnt), 32'd1);
        ifa.note_in = 4'd7;
        cyc(1);
        check_eq("t3_score", 32'(ifa.score), 32'd1);
        ifa.note_in = 4'd12;
        wait_done_a("t3_done", 10);
        ifa.note_in = 4'd0;
        check_eq("t3_miss_end", 32'(ifa.miss_cnt), 32'd1);

        // Held key must not match the repeated note
        load_rom_a(4'd6, 4'd6, 4'd0);
        start_a();
        cyc(2);
        check_eq("t4_led6", 32'(ifa.led_out), 32'b0000010);
        ifa.note_in = 4'd6;
        cyc(20);
        check_eq("t4_score_held", 32'(ifa.score),   32'd1);
        check_eq("t4_led_held",   32'(ifa.led_out), 32'd0);
        check_eq("t4_busy_held",  32'(ifa.busy),    32'd1);
        ifa.note_in = 4'd0;
        cyc(3);
        check_eq("t4_led6b", 32'(ifa.led_out), 32'b0000010);
        ifa.note_in = 4'd6;
        cyc(1);
        check_eq("t4_score2", 32'(ifa.score), 32'd2);
        ifa.note_in = 4'd0;
        wait_done_a("t4_done", 10);

        // Start while busy is ignored; reset mid-SHOW clears everything
        load_rom_a(4'd1, 4'd2, 4'd0);
        start_a();
        cyc(2);
        check_eq("t5_led1", 32'(ifa.led_out), 32'b1000000);
        ifa.note_in = 4'd1;
        cyc(1);
        check_eq("t5_score", 32'(ifa.score), 32'd1);
        ifa.note_in = 4'd0;
        cyc(1);
        ifa.start = 1'b1;
        cyc(1);
        ifa.start = 1'b0;
        check_eq("t5_addr_kept",  32'(ifa.rom_addr), 32'd1);
        check_eq("t5_score_kept", 32'(ifa.score),    32'd1);
        cyc(1);
        check_eq("t5_led2", 32'(ifa.led_out), 32'b0100000);
        ifa.note_in = 4'd3;
        cyc(1);
        check_eq("t5_wrong", 32'(ifa.wrong),    32'd1);
        check_eq("t5_miss",  32'(ifa.miss_cnt), 32'd1);
        rst = 1'b1;
        cyc(1);
        check_eq("t5_rst_addr",  32'(ifa.rom_addr), 32'd0);
        check_eq("t5_rst_led",   32'(ifa.led_out),  32'd0);
        check_eq("t5_rst_busy",  32'(ifa.busy),     32'd0);
        check_eq("t5_rst_wrong", 32'(ifa.wrong),    32'd0);
        check_eq("t5_rst_score", 32'(ifa.score),    32'd0);
        check_eq("t5_rst_miss",  32'(ifa.miss_cnt), 32'd0);
        rst = 1'b0;
        ifa.note_in = 4'd0;
        cyc(1);
        check_eq("t5_idle", 32'(ifa.busy), 32'd0);

        // 4-entry song of 1s: miss saturation on note 0, then wrap-free end
        ifb.start = 1'b1;
        cyc(1);
        ifb.start = 1'b0;
        cyc(2);
        check_eq("t6_led1", 32'(ifb.led_out), 32'b1000000);
        for (int i = 0; i < 260; i++) begin
            ifb.note_in = 4'd2;
            cyc(1);
            ifb.note_in = 4'd0;
            cyc(1);
        end
        check_eq("t6_miss_sat", 32'(ifb.miss_cnt), 32'd255);
        check_eq("t6_led_still", 32'(ifb.led_out), 32'b1000000);
        ifb.note_in = 4'd1;
        cyc(1);
        check_eq("t6_score1", 32'(ifb.score), 32'd1);
        ifb.note_in = 4'd0;
        for (int n = 2; n <= 4; n++) begin
            cyc(3);
            check_eq("t6_led_n", 32'(ifb.led_out), 32'b1000000);
            ifb.note_in = 4'd1;
            cyc(1);
            check_eq("t6_score_n", 32'(ifb.score), 32'(n));
            ifb.note_in = 4'd0;
        end
        cyc(1);
        check_eq("t6_done", 32'(ifb.done),     32'd1);
        check_eq("t6_busy", 32'(ifb.busy),     32'd0);
        check_eq("t6_addr", 32'(ifb.rom_addr), 32'd3);
        cyc(3);
        check_eq("t6_no_fifth",  32'(ifb.busy),     32'd0);
        check_eq("t6_led_dark",  32'(ifb.led_out),  32'd0);
        check_eq("t6_miss_hold", 32'(ifb.miss_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
